// File: rtl/mem_sim_pkg.sv
// Shared types and helpers for the behavioural refill-memory responder.
package mem_sim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_LINE_W  = 128;
  localparam int unsigned DEF_LATENCY = 4;

  // Byte address of word idx within a line starting at base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input int unsigned idx);
    return base + 32'(idx << 2);
  endfunction

endpackage

// File: rtl/mem_line_gen.sv
// Combinational line pattern: word i = (base + 4*i) ^ SEED.
module mem_line_gen
  import mem_sim_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LINE_W = DEF_LINE_W,
  parameter logic [31:0] SEED   = 32'h0
) (
  input  logic [ADDR_W-1:0] base,
  output logic [LINE_W-1:0] line
);

  localparam int unsigned WORDS = LINE_W / 32;

  // base is line-aligned, so adding word offsets in 32 bits never carries into upper bits.
  always_comb begin
    line = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      line[32*i +: 32] = word_addr(32'(base), i) ^ SEED;
    end
  end

endmodule

// File: rtl/mem_sim.sv
// Fixed-latency main-memory responder for I-cache refills: one line per accepted request.
module mem_sim
  import mem_sim_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned LINE_W  = DEF_LINE_W,
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter logic [31:0] SEED    = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ready,
  output logic [LINE_W-1:0] mem_data_in
);

  localparam int unsigned OFS   = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFS) - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ADDR_W-1:0] base, base_next;
  logic              ready_next;
  logic [LINE_W-1:0] data_next;
  logic [LINE_W-1:0] line;

  mem_line_gen #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .SEED   (SEED)
  ) u_line_gen (
    .base (base),
    .line (line)
  );

  // RESP is the cycle whose closing edge raises mem_ready, so the strobe lands LATENCY edges after acceptance.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    base_next  = base;
    ready_next = 1'b0;
    data_next  = mem_data_in;
    case (state)
      IDLE: begin
        if (mem_req) begin
          base_next = mem_addr & ALIGN_MASK;
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        ready_next = 1'b1;
        data_next  = line;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      base        <= '0;
      mem_ready   <= 1'b0;
      mem_data_in <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      base        <= base_next;
      mem_ready   <= ready_next;
      mem_data_in <= data_next;
    end
  end

endmodule

// File: tb/tb_mem_sim.sv
// Directed bench for mem_sim: latency, line pattern, request handling and reset abort.
module tb_mem_sim;

  logic         clk;
  logic         rst_n;
  logic         req_a, req_b;
  logic [31:0]  addr_a, addr_b;
  logic         ready_a, ready_b;
  logic [127:0] data_a, data_b;

  int n_assert;
  int n_fail;

  mem_sim #(
    .ADDR_W  (32),
    .LINE_W  (128),
    .LATENCY (4),
    .SEED    (32'h0)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (req_a),
    .mem_addr    (addr_a),
    .mem_ready   (ready_a),
    .mem_data_in (data_a)
  );

  mem_sim #(
    .ADDR_W  (32),
    .LINE_W  (128),
    .LATENCY (1),
    .SEED    (32'hA5A5_A5A5)
  ) u_seed (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (req_b),
    .mem_addr    (addr_b),
    .mem_ready   (ready_b),
    .mem_data_in (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int first;
    logic seen;

    n_assert = 0;
    n_fail   = 0;
    rst_n  = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    addr_a = 'x;
    addr_b = 'x;

    step();
    step();
    chk("reset_ready", {127'b0, ready_a}, 128'h0);
    chk("reset_data", data_a, 128'h0);
    chk("reset_data_seed", data_b, 128'h0);
    rst_n = 1'b1;
    step();
    chk("idle_x_addr_ready", {127'b0, ready_a}, 128'h0);

    // Single request; req drops after acceptance but the access completes.
    addr_a = 32'h1234_5678;
    req_a  = 1'b1;
    step();
    req_a  = 1'b0;
    addr_a = 'x;
    chk("single_e0_ready", {127'b0, ready_a}, 128'h0);
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("single_ready_c%0d", c), {127'b0, ready_a}, {127'b0, (c == 4)});
      if (c == 4) chk("single_data", data_a, 128'h1234567C_12345678_12345674_12345670);
    end
    chk("single_data_hold", data_a, 128'h1234567C_12345678_12345674_12345670);

    // Top of address space.
    addr_a = 32'hFFFF_FFFF;
    req_a  = 1'b1;
    step();
    req_a = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    chk("top_ready", {127'b0, ready_a}, 128'h1);
    chk("top_data", data_a, 128'hFFFFFFFC_FFFFFFF8_FFFFFFF4_FFFFFFF0);
    step();
    chk("top_ready_fall", {127'b0, ready_a}, 128'h0);

    // Short pulse: req high for 1.5 cycles.
    addr_a = 32'h0000_0100;
    req_a  = 1'b1;
    #15;
    req_a = 1'b0;
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (ready_a === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    chk("pulse_count", 128'(pulses), 128'd1);
    chk("pulse_pos", 128'(first), 128'd4);
    chk("pulse_data", data_a, 128'h0000010C_00000108_00000104_00000100);

    // Held request with the address changing during WAIT.
    addr_a = 32'h0000_1000;
    req_a  = 1'b1;
    step();
    addr_a = 32'h2000_004B;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 6) req_a = 1'b0;
      chk($sformatf("held_ready_c%0d", c), {127'b0, ready_a}, {127'b0, (c == 4 || c == 9)});
      if (c == 4) chk("held_data1", data_a, 128'h0000100C_00001008_00001004_00001000);
      if (c == 9) chk("held_data2", data_a, 128'h2000004C_20000048_20000044_20000040);
    end

    // Reset in the middle of WAIT aborts the access.
    addr_a = 32'h0000_3330;
    req_a  = 1'b1;
    step();
    req_a = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {127'b0, ready_a}, 128'h0);
    chk("abort_data", data_a, 128'h0);
    step();
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (ready_a !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_strobe", {127'b0, seen}, 128'h0);
    chk("abort_data_stays", data_a, 128'h0);

    // LATENCY=1 with SEED mask.
    addr_b = 32'h0000_0000;
    req_b  = 1'b1;
    step();
    req_b = 1'b0;
    chk("seed_e0_ready", {127'b0, ready_b}, 128'h0);
    step();
    chk("seed_ready", {127'b0, ready_b}, 128'h1);
    chk("seed_data", data_b, 128'hA5A5A5A9_A5A5A5AD_A5A5A5A1_A5A5A5A5);
    step();
    chk("seed_ready_fall", {127'b0, ready_b}, 128'h0);
    chk("seed_data_hold", data_b, 128'hA5A5A5A9_A5A5A5AD_A5A5A5A1_A5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
